// File: rtl/dac_interp_linear.sv
// Linear interpolator: stretches each low-rate signed sample over 2**OSR_LOG2
// clk cycles by ramping from the previous sample to the current one.
// Ports:
//   clk, rst_n_i (sync, active-low)
//   s_valid_i / s_data_i / s_ready_o : low-rate sample input handshake
//   dac_o       : interpolated sample, one per clk
//   seg_start_o : one-cycle pulse when a new segment is loaded
//   underrun_o  : sticky flag, no sample ready at segment end
module dac_interp_linear #(
   parameter int BW       = 16,
   parameter int OSR_LOG2 = 6
) (
   input  logic                 clk,
   input  logic                 rst_n_i,
   input  logic                 s_valid_i,
   input  logic signed [BW-1:0] s_data_i,
   output logic                 s_ready_o,
   output logic signed [BW-1:0] dac_o,
   output logic                 seg_start_o,
   output logic                 underrun_o
);

   localparam int W = BW + 1 + OSR_LOG2;

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   state_e                state_q, state_d;
   logic [OSR_LOG2-1:0]   phase_q, phase_d;
   logic signed [BW-1:0]  prev_q, prev_d;
   logic signed [BW-1:0]  curr_q, curr_d;
   logic signed [BW-1:0]  hold_q, hold_d;
   logic                  full_q, full_d;
   logic signed [BW-1:0]  dac_q, dac_d;
   logic                  seg_q, seg_d;
   logic                  und_q, und_d;

   logic                  accept;
   logic                  wrap;

   logic signed [BW:0]    diff;
   logic signed [W-1:0]   diff_x;
   logic signed [W-1:0]   ph_x;
   logic signed [W-1:0]   base;
   logic signed [W-1:0]   prod;
   logic signed [W-1:0]   sum;
   logic [OSR_LOG2:0]     sum_unused;

   assign accept = s_valid_i & ~full_q;
   assign wrap   = (phase_q == '1);

   // prev*OSR + (curr-prev)*phase, wide enough that no input pair overflows
   assign diff   = {curr_q[BW-1], curr_q} - {prev_q[BW-1], prev_q};
   assign diff_x = {{OSR_LOG2{diff[BW]}}, diff};
   assign ph_x   = {{(BW + 1){1'b0}}, phase_q};
   assign base   = {prev_q[BW-1], prev_q, {OSR_LOG2{1'b0}}};
   assign prod   = diff_x * ph_x;
   assign sum    = base + prod;

   // Taking bits above OSR_LOG2 is an arithmetic shift (floor); the result
   // is known to fit BW bits, so the top bit is redundant.
   assign sum_unused = {sum[W-1], sum[OSR_LOG2-1:0]};

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      prev_d  = prev_q;
      curr_d  = curr_q;
      hold_d  = hold_q;
      full_d  = full_q;
      und_d   = und_q;
      seg_d   = 1'b0;
      dac_d   = '0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               curr_d  = s_data_i;
               prev_d  = '0;
               phase_d = '0;
               seg_d   = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            dac_d   = sum[OSR_LOG2+BW-1:OSR_LOG2];
            phase_d = phase_q + 1'b1;
            if (wrap) begin
               seg_d  = 1'b1;
               prev_d = curr_q;
               if (full_q) begin
                  curr_d = hold_q;
                  full_d = 1'b0;
               end else if (accept) begin
                  // bypass: sample lands straight in curr
                  curr_d = s_data_i;
               end else begin
                  und_d = 1'b1;
               end
            end else if (accept) begin
               hold_d = s_data_i;
               full_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         phase_q <= '0;
         prev_q  <= '0;
         curr_q  <= '0;
         hold_q  <= '0;
         full_q  <= 1'b0;
         dac_q   <= '0;
         seg_q   <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         prev_q  <= prev_d;
         curr_q  <= curr_d;
         hold_q  <= hold_d;
         full_q  <= full_d;
         dac_q   <= dac_d;
         seg_q   <= seg_d;
         und_q   <= und_d;
      end
   end

   assign s_ready_o   = ~full_q;
   assign dac_o       = dac_q;
   assign seg_start_o = seg_q;
   assign underrun_o  = und_q;

endmodule

// File: tb/tb_dac_interp_linear.sv
// Bench for dac_interp_linear (BW=16, OSR_LOG2=2).
// Directed steps push expected dac_o ramps; a monitor pops them per segment.
module tb_dac_interp_linear;

   localparam int BW  = 16;
   localparam int OSL = 2;
   localparam int OSR = 4;

   logic                 clk;
   logic                 rst_n_i;
   logic                 s_valid_i;
   logic signed [BW-1:0] s_data_i;
   logic                 s_ready_o;
   logic signed [BW-1:0] dac_o;
   logic                 seg_start_o;
   logic                 underrun_o;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   dac_interp_linear #(.BW(BW), .OSR_LOG2(OSL)) dut (
      .clk        (clk),
      .rst_n_i    (rst_n_i),
      .s_valid_i  (s_valid_i),
      .s_data_i   (s_data_i),
      .s_ready_o  (s_ready_o),
      .dac_o      (dac_o),
      .seg_start_o(seg_start_o),
      .underrun_o (underrun_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push4(input int a, input int b, input int c, input int d);
      exp_q.push_back(a);
      exp_q.push_back(b);
      exp_q.push_back(c);
      exp_q.push_back(d);
   endtask

   // A seg_start_o pulse announces a segment whose OSR values appear
   // on dac_o in the following OSR cycles.
   initial begin : monitor
      int cnt;
      int e;
      cnt = 0;
      forever begin
         tick();
         if (!rst_n_i) cnt = 0;
         if (cnt > 0) begin
            cnt--;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               assert (int'(dac_o) === e) else begin
                  errors++;
                  $error("FAIL dac_seg observed=%0d expected=%0d",
                         dac_o, e);
               end
            end
         end
         if (seg_start_o && rst_n_i) cnt = OSR;
      end
   end

   initial begin
      rst_n_i   = 1'b0;
      s_valid_i = 1'b0;
      s_data_i  = '0;
      tick();
      tick();
      chk("rst_dac", int'(dac_o), 0);
      chk("rst_seg", int'(seg_start_o), 0);
      chk("rst_und", int'(underrun_o), 0);
      chk("rst_rdy", int'(s_ready_o), 1);
      rst_n_i = 1'b1;

      // first sample in IDLE, then 200 into the holding register
      s_valid_i = 1'b1;
      s_data_i  = 16'sd100;
      push4(0, 25, 50, 75);
      tick();
      chk("idle_seg", int'(seg_start_o), 1);
      s_data_i = 16'sd200;
      push4(100, 125, 150, 175);
      tick();
      s_valid_i = 1'b0;
      chk("hold_rdy1", int'(s_ready_o), 0);
      chk("seg_off", int'(seg_start_o), 0);
      tick();
      chk("hold_rdy2", int'(s_ready_o), 0);
      tick();
      chk("hold_rdy3", int'(s_ready_o), 0);
      tick();
      chk("wrap_rdy", int'(s_ready_o), 1);
      chk("wrap_seg", int'(seg_start_o), 1);
      chk("und_pre", int'(underrun_o), 0);

      // nothing offered: underrun holds curr
      push4(200, 200, 200, 200);
      tick();
      tick();
      tick();
      chk("und_pre2", int'(underrun_o), 0);
      tick();
      chk("und_set", int'(underrun_o), 1);
      chk("und_seg", int'(seg_start_o), 1);
      repeat (5) tick();
      chk("und_sticky", int'(underrun_o), 1);

      // floor rounding of a negative ramp
      rst_n_i = 1'b0;
      tick();
      tick();
      chk("rst2_und", int'(underrun_o), 0);
      rst_n_i   = 1'b1;
      s_valid_i = 1'b1;
      s_data_i  = -16'sd3;
      push4(0, -1, -2, -3);
      tick();
      s_valid_i = 1'b0;
      repeat (5) tick();

      // full-scale swing with no overflow, then bypass at the wrap
      rst_n_i = 1'b0;
      tick();
      tick();
      rst_n_i   = 1'b1;
      s_valid_i = 1'b1;
      s_data_i  = 16'sd32767;
      push4(0, 8191, 16383, 24575);
      tick();
      s_data_i = -16'sd32768;
      push4(32767, 16383, -1, -16385);
      tick();
      s_valid_i = 1'b0;
      repeat (3) tick();
      chk("fs_rdy", int'(s_ready_o), 1);
      repeat (3) tick();
      s_valid_i = 1'b1;
      s_data_i  = 16'sd1000;
      exp_q.push_back(-32768);
      exp_q.push_back(-24326);
      chk("byp_rdy", int'(s_ready_o), 1);
      tick();
      chk("byp_full", int'(s_ready_o), 1);
      chk("byp_und", int'(underrun_o), 0);
      chk("byp_seg", int'(seg_start_o), 1);
      s_data_i = 16'sd7;
      tick();
      s_valid_i = 1'b0;
      chk("mid_hold", int'(s_ready_o), 0);
      tick();

      // reset mid-segment with a sample offered
      rst_n_i   = 1'b0;
      s_valid_i = 1'b1;
      s_data_i  = 16'sd5;
      tick();
      chk("mrst_dac", int'(dac_o), 0);
      chk("mrst_seg", int'(seg_start_o), 0);
      chk("mrst_und", int'(underrun_o), 0);
      chk("mrst_rdy", int'(s_ready_o), 1);
      rst_n_i   = 1'b1;
      s_valid_i = 1'b0;
      tick();
      tick();
      chk("post_seg", int'(seg_start_o), 0);
      chk("post_dac", int'(dac_o), 0);
      chk("post_rdy", int'(s_ready_o), 1);
      chk("sb_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dac_interp_linear.md
DAC_INTERP_LINEAR -- requirements
Module: dac_interp_linear

Interface
REQ-001 The block SHALL have parameter BW, default 16, meaning the signed sample width on the input and output.
REQ-002 The block SHALL have parameter OSR_LOG2, default 6, meaning log2 of the oversampling ratio (OSR = 2**OSR_LOG2 clk cycles per input sample).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit, the reset; it is synchronous and active-low.
REQ-005 The block SHALL have port s_valid_i, input, 1 bit, asserted when a low-rate sample is offered.
REQ-006 The block SHALL have port s_data_i, input, BW bits, the signed two's-complement low-rate sample.
REQ-007 The block SHALL have port s_ready_o, output, 1 bit, asserted when the block can take a sample.
REQ-008 The block SHALL have port dac_o, output, BW bits, the signed interpolated sample, one per clk, feeding the sigma-delta modulator input.
REQ-009 The block SHALL have port seg_start_o, output, 1 bit, a one-cycle pulse when a new interpolation segment is loaded.
REQ-010 The block SHALL have port underrun_o, output, 1 bit, a sticky flag set when no sample is available at segment end.

Function
REQ-011 Internal state SHALL comprise: the FSM {IDLE, RUN}; a phase counter (OSR_LOG2 bits); signed registers prev and curr (BW bits); and a one-entry holding register with a full flag.
REQ-012 s_ready_o SHALL equal NOT full, as a registered flag with no combinational path from s_valid_i.
REQ-013 A sample SHALL be accepted on any cycle with s_valid_i=1 and s_ready_o=1.
REQ-014 In IDLE, an accepted sample SHALL load curr=sample and prev=0, clear phase, pulse seg_start_o and enter RUN on the next cycle; it SHALL NOT enter the holding register.
REQ-015 In RUN, an accepted sample SHALL be written to the holding register (full<=1), except in the bypass case of REQ-017.
REQ-016 In RUN, phase SHALL increment every cycle and wrap from OSR-1 to 0.
REQ-017 At the wrap cycle (phase=OSR-1), segment load SHALL proceed as follows:
- If full: prev<=curr, curr<=holding, full<=0.
- Else if a sample is accepted in the same cycle (bypass): prev<=curr, curr<=s_data_i, and full stays 0.
- Else (underrun): prev<=curr, curr<=curr, underrun_o<=1.
REQ-018 seg_start_o SHALL pulse in the cycle after every wrap, including the underrun case.
REQ-019 dac_o SHALL be registered: dac_o(t+1) = floor((prev*OSR + (curr-prev)*phase) / OSR) evaluated on the cycle-t values, using arithmetic right shift by OSR_LOG2.
REQ-020 The difference curr-prev SHALL be computed at BW+1 bits and the product/sum at BW+1+OSR_LOG2 bits, so that no overflow occurs for any input pair; the result SHALL always lie between prev and curr inclusive.
REQ-021 In IDLE, dac_o SHALL be 0.
REQ-022 The block SHALL never leave RUN except on reset.
REQ-023 underrun_o SHALL stay set until reset.

Reset
REQ-024 When rst_n_i=0 at a rising edge, the block SHALL enter IDLE and set phase=0, prev=0, curr=0, full=0, dac_o=0, seg_start_o=0, underrun_o=0, s_ready_o=1.
REQ-025 A reset mid-segment SHALL discard the holding register contents and any sample offered in the same cycle.

Verification (OSR_LOG2=2, BW=16)
REQ-026 Bench SHALL cover: reset, then accept 100 in IDLE -> seg_start_o pulse, then dac_o = 0,25,50,75.
REQ-027 Bench SHALL cover: hold 200 in the holding register before the wrap -> dac_o = 100,125,150,175, s_ready_o=0 until the wrap and 1 after it.
REQ-028 Bench SHALL cover: no sample at the wrap with curr=200 -> dac_o = 200,200,200,200, underrun_o=1 and staying 1.
REQ-029 Bench SHALL cover: prev=0, curr=-3 -> dac_o = 0,-1,-2,-3 (floor rounding).
REQ-030 Bench SHALL cover: prev=32767, curr=-32768 -> dac_o = 32767,16383,-1,-16385 with no wrap-around.
REQ-031 Bench SHALL cover: a sample offered exactly on a wrap cycle with the holding register empty -> bypass into curr, full stays 0, no underrun; then rst_n_i=0 mid-segment -> all outputs return to their reset values the next cycle.
